switch_alloc_rr: RTL
====================

SWITCH_ALLOC_RR -- requirements
Module: switch_alloc_rr

Interface
REQ-001 SHALL have parameter NPORTS, default 5, number of router ports (index 0 = local, 1 = W, 2 = N, 3 = E, 4 = S).
REQ-002 SHALL have parameter DATASIZE, default 40, flit width (src 4b, dst 4b, timestamp 8b, data 22b, type 2b).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, NPORTS, input i holds a flit at its buffer head.
REQ-006 SHALL have port in_dest, input, NPORTS*NPORTS, slice i = one-hot output request of input i.
REQ-007 SHALL have port in_data, input, NPORTS*DATASIZE, slice i = head flit of input i.
REQ-008 SHALL have port out_full, input, NPORTS, downstream of output o cannot accept.
REQ-009 SHALL have port in_ready, output, NPORTS, head flit of input i is consumed this cycle.
REQ-010 SHALL have port grant, output, NPORTS*NPORTS, slice o = one-hot winning input for output o (combinational).
REQ-011 SHALL have port out_valid, output, NPORTS, registered flit valid per output.
REQ-012 SHALL have port out_data, output, NPORTS*DATASIZE, registered flit per output.

Function
REQ-013 Input i SHALL request output o only when in_valid[i]=1 and bit o is the lowest set bit of in_dest slice i; in_dest slice = 0 means no request.
REQ-014 Each output o SHALL run an independent round-robin arbiter over its requesting inputs, searching from ptr[o] upward with wrap-around NPORTS-1 -> 0.
REQ-015 Output o SHALL issue no grant while out_full[o]=1.
REQ-016 A transfer on output o SHALL occur when grant slice o is non-zero; grant is at most one-hot per output and each input is granted by at most one output.
REQ-017 On a transfer to output o from winner w, ptr[o] SHALL become (w+1) mod NPORTS next cycle; otherwise ptr[o] holds.
REQ-018 in_ready[i] SHALL equal ~in_valid[i] OR (input i granted this cycle).
REQ-019 When out_full[o]=0: out_valid[o] <= (grant slice o non-zero), out_data[o] <= winning in_data slice, or hold previous out_data when no grant.
REQ-020 When out_full[o]=1: out_valid[o] and out_data[o] SHALL hold their values.
REQ-021 Latency SHALL be one cycle from grant to out_valid.
REQ-022 Simultaneous requests from all NPORTS inputs to one output SHALL be served one per cycle, each input exactly once in NPORTS consecutive unstalled cycles.
REQ-023 U-turn requests (input i to output i) SHALL be arbitrated like any other request.

Reset
REQ-024 On rst_n=0, asynchronously: out_valid=0, out_data=0, all ptr[o]=0.
REQ-025 Reset mid-transfer SHALL discard registered flits; first grant after release SHALL favour input 0.
REQ-026 While rst_n=0, combinational grant and in_ready SHALL still follow REQ-013..018 from ptr=0.

Structure
REQ-027 Port index constants, NPORTS and DATASIZE defaults SHALL live in shared package noc_pkg.
REQ-028 Arbitration SHALL be a sub-module rr_arbiter (parameter N; req, enable, grant, pointer state), instantiated NPORTS times by generate.
REQ-029 Target size SHALL be 120-400 lines of RTL, no latches, no multi-driven nets.

Verification
REQ-030 Reset release, all in_valid=0 -> out_valid=00000, in_ready=11111, grant all zero.
REQ-031 Inputs 0,2,3 all request output 3, out_full=0, held 3 cycles -> grants 0,2,3 in order; out_data[3] shows flits of 0,2,3 on cycles 1-3.
REQ-032 Input 1 requests output 2 with out_full[2]=1 for 4 cycles -> in_ready[1]=0, out_valid[2] and out_data[2] frozen; first cycle after full drops -> grant, flit appears next cycle.
REQ-033 Five inputs each to a distinct output (permutation) -> five grants same cycle, all in_ready=1, all out_valid=1 next cycle.
REQ-034 in_dest slice 0 = 01010 -> only output 1 granted; output 3 sees no request.
REQ-035 Assert rst_n low mid-stream with ptr[3]=2 -> out_valid=0 immediately; after release, contention at output 3 between inputs 1 and 4 grants input 1 first.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg -- constants and flit layout shared by the router blocks.
//
// Contents:
//   NPORTS_DEF / DATASIZE_DEF : default port count and flit width
//   PORT_*                    : router port indices (local, W, N, E, S)
//   flit_type_e / flit_t      : flit field layout, MSB first
//                               (src 4b, dst 4b, timestamp 8b, data 22b, type 2b)
package noc_pkg;

    localparam int NPORTS_DEF   = 5;
    localparam int DATASIZE_DEF = 40;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_W     = 1;
    localparam int PORT_N     = 2;
    localparam int PORT_E     = 3;
    localparam int PORT_S     = 4;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [7:0]  tstamp;
        logic [21:0] payload;
        flit_type_e  ftype;
    } flit_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- single round-robin arbiter with an internal priority pointer.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req[N]     : request vector
//   enable     : when low no grant is issued and the pointer holds
//   grant[N]   : one-hot winner (combinational), search starts at the pointer
//                and wraps N-1 -> 0
// After a grant to input w the pointer moves to (w+1) mod N.
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_next;
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;
    logic [PW-1:0]  winner;

    // Rotate requests so the pointer position lands at bit 0, take the lowest
    // set bit (x & -x), then rotate the one-hot result back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        gnt_rot = enable ? (req_rot & (-req_rot)) : '0;
        gnt_dbl = {gnt_rot, gnt_rot} << ptr;
        grant   = gnt_dbl[2*N-1:N];
    end

    // NOTE: every variable assigned in an always_comb gets a default before any
    // conditional assignment, otherwise a latch is inferred.
    always_comb begin
        winner = '0;
        for (int j = 0; j < N; j++) begin
            if (grant[j]) winner = PW'(j);
        end
        ptr_next = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // values from before the edge; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr -- per-output round-robin switch allocator with registered
// output stage.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : [NPORTS]          input i has a head flit
//   in_dest    : [NPORTS*NPORTS]   slice i = one-hot output request of input i
//   in_data    : [NPORTS*DATASIZE] slice i = head flit of input i
//   out_full   : [NPORTS]          downstream of output o cannot accept
//   in_ready   : [NPORTS]          head flit of input i is consumed this cycle
//   grant      : [NPORTS*NPORTS]   slice o = one-hot winning input (combinational)
//   out_valid  : [NPORTS]          registered flit valid per output
//   out_data   : [NPORTS*DATASIZE] registered flit per output
module switch_alloc_rr
    import noc_pkg::*;
#(
    parameter int NPORTS   = NPORTS_DEF,
    parameter int DATASIZE = DATASIZE_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NPORTS-1:0]          in_valid,
    input  logic [NPORTS*NPORTS-1:0]   in_dest,
    input  logic [NPORTS*DATASIZE-1:0] in_data,
    input  logic [NPORTS-1:0]          out_full,
    output logic [NPORTS-1:0]          in_ready,
    output logic [NPORTS*NPORTS-1:0]   grant,
    output logic [NPORTS-1:0]          out_valid,
    output logic [NPORTS*DATASIZE-1:0] out_data
);

    logic [NPORTS-1:0]   dest_lo  [NPORTS];  // per input: lowest set dest bit
    logic [NPORTS-1:0]   req_mat  [NPORTS];  // per output: requesting inputs
    logic [NPORTS-1:0]   gnt_mat  [NPORTS];  // per output: granted input
    logic [DATASIZE-1:0] win_data [NPORTS];  // per output: winning flit
    logic [NPORTS-1:0]   granted;            // per input: granted by any output

    // A multi-hot destination only requests its lowest output, so each input
    // asks for at most one output and can never win two at once.
    for (genvar i = 0; i < NPORTS; i++) begin : g_dest
        assign dest_lo[i] = in_dest[i*NPORTS +: NPORTS] & (-in_dest[i*NPORTS +: NPORTS]);
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            req_mat[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req_mat[o][i] = in_valid[i] & dest_lo[i][o];
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arbiter #(.N(NPORTS)) u_arb (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (req_mat[o]),
            .enable (~out_full[o]),
            .grant  (gnt_mat[o])
        );
        assign grant[o*NPORTS +: NPORTS] = gnt_mat[o];
    end

    always_comb begin
        granted = '0;
        for (int o = 0; o < NPORTS; o++) begin
            granted = granted | gnt_mat[o];
        end
        in_ready = ~in_valid | granted;
    end

    // One-hot AND-OR mux of the winning flit per output.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            win_data[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (gnt_mat[o][i]) win_data[o] = win_data[o] | in_data[i*DATASIZE +: DATASIZE];
            end
        end
    end

    // Output stage freezes while downstream is full; with no grant the valid
    // drops but the last flit stays on out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (!out_full[o]) begin
                    out_valid[o] <= |gnt_mat[o];
                    if (|gnt_mat[o]) out_data[o*DATASIZE +: DATASIZE] <= win_data[o];
                end
            end
        end
    end

endmodule
